// File: rtl/data_memory_sized_pkg.sv
// ============================================================================
// Module : data_mem_pkg
// Brief  : Shared encodings for the sized data memory (access sizes, FSM states)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Latency counter holds values 0..LATENCY-1; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    return (latency < 2) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_sized_if.sv
// ============================================================================
// Module : data_memory_sized_if
// Brief  : Request/acknowledge access bus between the MEM stage and data memory
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_memory_sized_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       data_i;
  logic              busy_o;
  logic              ack_o;
  logic [31:0]       data_o;
  logic              err_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, data_i,
    input  busy_o, ack_o, data_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, data_i,
    output busy_o, ack_o, data_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/data_memory_sized_dm_lane_align.sv
// ============================================================================
// Module : dm_lane_align
// Brief  : Byte-enable/index generation, range/alignment error and load extension.
//          `DATA_MEM_ALIGN_CHK_EN: misaligned half/word raise an error instead
//          of being rounded down to natural alignment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_lane_align
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024
) (
  input  logic [1:0]                     size_i,
  input  logic                           unsigned_i,
  input  logic [ADDR_W-1:0]              addr_i,
  input  logic [31:0]                    rword_i,
  output logic [$clog2(DEPTH_BYTES)-1:0] idx_o,
  output logic [3:0]                     be_o,
  output logic [31:0]                    load_o,
  output logic                           err_o
);

  localparam int              AW    = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH_BYTES);

  logic [ADDR_W-1:0] w_eff;
  logic [1:0]        w_extra;
  logic              w_mis;
  logic [ADDR_W:0]   w_last;

  always_comb begin
    w_eff   = addr_i;
    w_extra = 2'd0;
    w_mis   = 1'b0;
    be_o    = 4'b0000;
    case (size_i)
      SZ_BYTE: begin
        be_o = 4'b0001;
      end
      SZ_HALF: begin
        be_o    = 4'b0011;
        w_extra = 2'd1;
`ifdef DATA_MEM_ALIGN_CHK_EN
        w_mis = addr_i[0];
`else
        w_eff[0] = 1'b0;
`endif
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        w_extra = 2'd3;
`ifdef DATA_MEM_ALIGN_CHK_EN
        w_mis = |addr_i[1:0];
`else
        w_eff[1:0] = 2'b00;
`endif
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
    // Extra top bit keeps the last-byte address from wrapping past 2^ADDR_W.
    w_last = {1'b0, w_eff} + {{(ADDR_W-1){1'b0}}, w_extra};
    err_o  = (size_i == SZ_RSVD) || w_mis || (w_last >= LIMIT);
    idx_o  = w_eff[AW-1:0];
  end

  always_comb begin
    case (size_i)
      SZ_BYTE: load_o = {{24{~unsigned_i & rword_i[7]}},  rword_i[7:0]};
      SZ_HALF: load_o = {{16{~unsigned_i & rword_i[15]}}, rword_i[15:0]};
      SZ_WORD: load_o = rword_i;
      default: load_o = 32'h0000_0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_memory_sized.sv
// ============================================================================
// Module : data_memory_sized
// Brief  : Byte-addressed little-endian data memory, req/ack with LATENCY cycles.
//          Build option `DATA_MEM_ALIGN_CHK_EN enables misalignment errors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_memory_sized
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  data_memory_sized_if.slave                bus,
  input  logic [$clog2(DEPTH_BYTES/4)-1:0]  dbg_idx_i,
  output logic [31:0]                       dbg_data_o
);

  localparam int            AW       = $clog2(DEPTH_BYTES);
  localparam int            CW       = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  logic [7:0]        r_mem [DEPTH_BYTES];
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_ack;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic              r_we;
  logic              r_uns;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_accept;
  logic              w_done;
  logic              w_write;
  logic              w_err;
  logic [AW-1:0]     w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_rword;
  logic [31:0]       w_load;

  dm_lane_align #(
    .ADDR_W      (ADDR_W),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_lane (
    .size_i     (r_size),
    .unsigned_i (r_uns),
    .addr_i     (r_addr),
    .rword_i    (w_rword),
    .idx_o      (w_idx),
    .be_o       (w_be),
    .load_o     (w_load),
    .err_o      (w_err)
  );

  // Lanes past the end wrap here, but such accesses are errors and discarded.
  assign w_rword = {r_mem[w_idx + AW'(3)], r_mem[w_idx + AW'(2)],
                    r_mem[w_idx + AW'(1)], r_mem[w_idx]};

  assign w_accept = (r_state == IDLE) && bus.req_i && !r_busy;
  assign w_done   = (r_state == WAIT) && (r_cnt == '0);
  assign w_write  = w_done && r_we && !w_err && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0000_0000;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= SZ_BYTE;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          // busy stays up through the ack cycle, blocking a same-cycle accept.
          if (r_ack) r_busy <= 1'b0;
          if (w_accept) begin
            r_we    <= bus.we_i;
            r_uns   <= bus.unsigned_i;
            r_size  <= bus.size_i;
            r_addr  <= bus.addr_i;
            r_wdata <= bus.data_i;
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_ack   <= 1'b1;
            r_err   <= w_err;
            if (w_err)      r_rdata <= 32'h0000_0000;
            else if (!r_we) r_rdata <= w_load;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_write) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx + AW'(k)] <= r_wdata[8*k +: 8];
      end
    end
  end

  assign dbg_data_o = {r_mem[{dbg_idx_i, 2'b11}], r_mem[{dbg_idx_i, 2'b10}],
                       r_mem[{dbg_idx_i, 2'b01}], r_mem[{dbg_idx_i, 2'b00}]};

  assign bus.busy_o = r_busy;
  assign bus.ack_o  = r_ack;
  assign bus.err_o  = r_err;
  assign bus.data_o = r_rdata;

endmodule

`default_nettype wire
